// File: rtl/npu_load_sched_pkg.sv
// Shared NPU memory map, region capacities, result codes and FSM state types.
package npu_load_sched_pkg;

  localparam logic [31:0] IMEM_BASE = 32'h8200_0000;
  localparam logic [31:0] WMEM_BASE = 32'h8200_3100;
  localparam logic [31:0] BMEM_BASE = 32'h8200_6200;
  localparam logic [31:0] OMEM_BASE = 32'h8200_6280;
  localparam logic [31:0] OP_BASE   = 32'h8200_8300;

  localparam logic [31:0] OP_CMD_OFF  = 32'h0000_0000;
  localparam logic [31:0] OP_STAT_OFF = 32'h0000_0004;

  localparam logic [15:0] IMEM_CAP = 16'd3136;
  localparam logic [15:0] WMEM_CAP = 16'd3136;
  localparam logic [15:0] BMEM_CAP = 16'd32;
  localparam logic [15:0] OMEM_CAP = 16'd2048;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  typedef enum logic [1:0] {MV_COPY, MV_WRITE, MV_READ} mv_op_e;

  typedef enum logic [2:0] {
    MV_IDLE, MV_RD_REQ, MV_RD_WAIT, MV_WR_REQ, MV_NEXT
  } mv_state_e;

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_LD_IN, S_LD_W, S_LD_B, S_KICK,
    S_POLL_WAIT, S_POLL, S_ST_O, S_FIN
  } sched_state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/npu_load_sched_mover.sv
// word_mover: single-outstanding read-then-write word engine on the system bus.
// COPY moves count words, WRITE issues one write of wr_value, READ issues one read.
module word_mover
  import npu_load_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  mv_op_e      op,
  input  logic [31:0] src,
  input  logic [31:0] dst,
  input  logic [31:0] wr_value,
  input  logic [15:0] count,
  output logic        phase_done,
  output logic        rd_flag,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  mv_state_e   state, state_nx;
  mv_op_e      op_q;
  logic [31:0] src_q, dst_q, hold;
  logic [15:0] cnt_q, idx;

  // State register plus latched job parameters, word index and data holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MV_IDLE;
      op_q  <= MV_COPY;
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      idx   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nx;
      if (state == MV_IDLE && go) begin
        op_q  <= op;
        src_q <= src;
        dst_q <= dst;
        cnt_q <= count;
        idx   <= '0;
        hold  <= wr_value;
      end
      if (state == MV_RD_WAIT && m_rvalid) hold <= m_rdata;
      if (state == MV_NEXT) idx <= idx + 16'd1;
    end
  end

  // Next state and bus drive; request fields are held constant while waiting for grant.
  always_comb begin
    state_nx   = state;
    phase_done = 1'b0;
    m_req      = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    case (state)
      MV_IDLE:    if (go) state_nx = (op == MV_WRITE) ? MV_WR_REQ : MV_RD_REQ;
      MV_RD_REQ: begin
        m_req  = 1'b1;
        m_addr = word_addr(src_q, idx);
        if (m_gnt) state_nx = MV_RD_WAIT;
      end
      MV_RD_WAIT: if (m_rvalid) state_nx = (op_q == MV_READ) ? MV_NEXT : MV_WR_REQ;
      MV_WR_REQ: begin
        m_req   = 1'b1;
        m_we    = 1'b1;
        m_addr  = word_addr(dst_q, idx);
        m_wdata = hold;
        if (m_gnt) state_nx = MV_NEXT;
      end
      MV_NEXT: begin
        if (idx + 16'd1 >= cnt_q) begin
          phase_done = 1'b1;
          state_nx   = MV_IDLE;
        end else begin
          state_nx = MV_RD_REQ;
        end
      end
      default: state_nx = MV_IDLE;
    endcase
  end

  assign rd_flag = hold[0];

endmodule

// File: rtl/npu_load_sched.sv
// npu_load_sched: runs one NPU job (load IMEM/WMEM/BMEM, kick, poll, store OMEM) as a bus master.
module npu_load_sched
  import npu_load_sched_pkg::*;
#(
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned POLL_MAX = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] src_in,
  input  logic [31:0] src_w,
  input  logic [31:0] src_b,
  input  logic [31:0] dst_o,
  input  logic [15:0] len_in,
  input  logic [15:0] len_w,
  input  logic [15:0] len_b,
  input  logic [15:0] len_o,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  sched_state_e state, state_nx, after;
  logic [31:0]  src_in_q, src_w_q, src_b_q, dst_o_q;
  logic [15:0]  len_in_q, len_w_q, len_b_q, len_o_q;
  logic [15:0]  gap_cnt, poll_cnt;
  logic         active, done_q, finish, poll_fail, accept;
  err_e         err_q, fin_code;

  logic         go, phase_done, rd_flag;
  mv_op_e       mv_op;
  logic [31:0]  mv_src, mv_dst;
  logic [15:0]  mv_cnt;

  assign accept = (state == S_IDLE) && start && !done_q;

  // Top-level state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Latched job parameters, phase/poll bookkeeping and registered done/err outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_in_q <= '0; src_w_q <= '0; src_b_q <= '0; dst_o_q <= '0;
      len_in_q <= '0; len_w_q <= '0; len_b_q <= '0; len_o_q <= '0;
      gap_cnt  <= '0;
      poll_cnt <= '0;
      active   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      if (accept) begin
        src_in_q <= {src_in[31:2], 2'b00};
        src_w_q  <= {src_w[31:2], 2'b00};
        src_b_q  <= {src_b[31:2], 2'b00};
        dst_o_q  <= {dst_o[31:2], 2'b00};
        len_in_q <= len_in;
        len_w_q  <= len_w;
        len_b_q  <= len_b;
        len_o_q  <= len_o;
        poll_cnt <= '0;
        err_q    <= ERR_OK;
      end
      if (go)              active <= 1'b1;
      else if (phase_done) active <= 1'b0;
      gap_cnt <= (state == S_POLL_WAIT) ? gap_cnt + 16'd1 : 16'd0;
      if (poll_fail) poll_cnt <= poll_cnt + 16'd1;
      done_q <= finish;
      if (finish) err_q <= fin_code;
    end
  end

  // Per-state word_mover job setup and the state that follows the phase.
  always_comb begin
    mv_op  = MV_COPY;
    mv_src = '0;
    mv_dst = '0;
    mv_cnt = '0;
    after  = S_IDLE;
    case (state)
      S_LD_IN: begin mv_src = src_in_q; mv_dst = IMEM_BASE; mv_cnt = len_in_q; after = S_LD_W; end
      S_LD_W:  begin mv_src = src_w_q;  mv_dst = WMEM_BASE; mv_cnt = len_w_q;  after = S_LD_B; end
      S_LD_B:  begin mv_src = src_b_q;  mv_dst = BMEM_BASE; mv_cnt = len_b_q;  after = S_KICK; end
      S_KICK:  begin mv_op = MV_WRITE; mv_dst = OP_BASE + OP_CMD_OFF; mv_cnt = 16'd1; after = S_POLL_WAIT; end
      S_POLL:  begin mv_op = MV_READ;  mv_src = OP_BASE + OP_STAT_OFF; mv_cnt = 16'd1; after = S_ST_O; end
      S_ST_O:  begin mv_src = OMEM_BASE; mv_dst = dst_o_q; mv_cnt = len_o_q; after = S_FIN; end
      default: ;
    endcase
  end

  // Next-state logic: length check, phase sequencing with zero-length skip, poll/timeout.
  always_comb begin
    state_nx  = state;
    go        = 1'b0;
    finish    = 1'b0;
    fin_code  = ERR_OK;
    poll_fail = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = S_CHK;
      S_CHK: begin
        if (len_in_q > IMEM_CAP || len_w_q > WMEM_CAP || len_b_q > BMEM_CAP || len_o_q > OMEM_CAP) begin
          finish   = 1'b1;
          fin_code = ERR_LEN;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_LD_IN;
        end
      end
      S_LD_IN, S_LD_W, S_LD_B, S_KICK, S_ST_O: begin
        if (!active) begin
          if (mv_cnt == 16'd0) state_nx = after;
          else                 go = 1'b1;
        end else if (phase_done) begin
          state_nx = after;
        end
      end
      S_POLL_WAIT: if ({16'd0, gap_cnt} + 32'd1 >= POLL_GAP) state_nx = S_POLL;
      S_POLL: begin
        if (!active) begin
          go = 1'b1;
        end else if (phase_done) begin
          if (rd_flag) begin
            state_nx = after;
          end else if ({16'd0, poll_cnt} + 32'd1 >= POLL_MAX) begin
            finish   = 1'b1;
            fin_code = ERR_TIMEOUT;
            state_nx = S_IDLE;
          end else begin
            poll_fail = 1'b1;
            state_nx  = S_POLL_WAIT;
          end
        end
      end
      S_FIN: begin
        finish   = 1'b1;
        fin_code = ERR_OK;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  word_mover u_mover (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .op         (mv_op),
    .src        (mv_src),
    .dst        (mv_dst),
    .wr_value   (32'h0000_0001),
    .count      (mv_cnt),
    .phase_done (phase_done),
    .rd_flag    (rd_flag),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_gnt      (m_gnt),
    .m_rvalid   (m_rvalid),
    .m_rdata    (m_rdata)
  );

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule
